// File: rtl/fifo_rr_drain_if.sv
// Output stream of the round-robin FIFO drainer: tagged words on a valid/ready handshake.
interface fifo_rr_drain_if #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4
);
    logic [WIDTH-1:0]        data;
    logic [$clog2(N_CH)-1:0] ch;
    logic                    valid;
    logic                    ready;
    logic                    last;

    modport master (output data, ch, valid, last, input ready);
    modport slave  (input data, ch, valid, last, output ready);
endinterface

// File: rtl/fifo_rr_drain.sv
// Round-robin drainer: grants one FWFT FIFO at a time for up to BURST words,
// pops only on downstream acceptance and tags each word with its source channel.
module fifo_rr_drain #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int BURST = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   ch_dout,
    input  logic [N_CH-1:0]         ch_empty,
    output logic [N_CH-1:0]         ch_rd_en,
    input  logic [N_CH-1:0]         cfg_en,
    fifo_rr_drain_if.master         m,
    output logic                    busy,
    output logic [CNT_W-1:0]        word_count
);
    localparam int CH_W = $clog2(N_CH);
    localparam int BC_W = $clog2(BURST + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST - 1);
    localparam logic [CH_W-1:0] CH_MAX     = CH_W'(N_CH - 1);

    typedef enum logic [0:0] {ARB = 1'b0, XFER = 1'b1} state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [CH_W-1:0]   grant_r;
    logic [CH_W-1:0]   last_grant_r;
    logic [BC_W-1:0]   burst_cnt_r;
    logic [CNT_W-1:0]  word_count_r;
    logic [N_CH-1:0]   req_s;
    logic              valid_s;
    logic              hs_s;
    logic              exit_s;

    // First requesting channel strictly after the previous grant, wrapping around.
    function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                input logic [CH_W-1:0] last);
        logic [CH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last) + k) % N_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign req_s      = cfg_en & ~ch_empty;
    assign word_count = word_count_r;

    // Next-state and handshake decode; outputs follow the granted FIFO head directly.
    always_comb begin
        state_nx_s = state_r;
        ch_rd_en   = '0;
        valid_s    = 1'b0;
        hs_s       = 1'b0;
        exit_s     = 1'b0;
        busy       = 1'b0;
        m.data     = ch_dout[int'(grant_r)*WIDTH +: WIDTH];
        m.ch       = grant_r;
        m.valid    = 1'b0;
        m.last     = 1'b0;
        case (state_r)
            ARB: begin
                if (|req_s) begin
                    state_nx_s = XFER;
                end else begin
                    state_nx_s = ARB;
                end
            end
            XFER: begin
                busy              = 1'b1;
                valid_s           = req_s[grant_r];
                hs_s              = valid_s & m.ready;
                m.valid           = valid_s;
                m.last            = valid_s & (burst_cnt_r == BURST_LAST);
                ch_rd_en[grant_r] = hs_s;
                // An emptied or disabled channel ends the burst without holding the grant.
                exit_s = (hs_s & (burst_cnt_r == BURST_LAST)) | ~valid_s;
                if (exit_s) begin
                    state_nx_s = ARB;
                end else begin
                    state_nx_s = XFER;
                end
            end
            default: begin
                state_nx_s = ARB;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant, burst and word counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r      <= '0;
            last_grant_r <= CH_MAX;
            burst_cnt_r  <= '0;
            word_count_r <= '0;
        end else if (state_r == ARB) begin
            if (|req_s) begin
                grant_r     <= rr_pick(req_s, last_grant_r);
                burst_cnt_r <= '0;
            end else begin
                grant_r     <= grant_r;
            end
        end else begin
            if (hs_s) begin
                burst_cnt_r  <= burst_cnt_r + BC_W'(1);
                word_count_r <= word_count_r + CNT_W'(1);
            end else begin
                burst_cnt_r  <= burst_cnt_r;
            end
            if (exit_s) begin
                last_grant_r <= grant_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain with behavioural FWFT FIFOs and a transfer log.
module tb_fifo_rr_drain;
    logic        clk;
    logic        rst;
    logic [31:0] ch_dout;
    logic [3:0]  ch_empty;
    logic [3:0]  ch_rd_en;
    logic [3:0]  cfg_en;
    logic        busy;
    logic [15:0] word_count;

    fifo_rr_drain_if #(.WIDTH(8), .N_CH(4)) mif ();

    fifo_rr_drain #(.WIDTH(8), .N_CH(4), .BURST(4), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_dout    (ch_dout),
        .ch_empty   (ch_empty),
        .ch_rd_en   (ch_rd_en),
        .cfg_en     (cfg_en),
        .m          (mif.master),
        .busy       (busy),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int fcnt [4];
    int fptr [4];
    int viol;
    int cyc;
    bit tog;
    logic [3:0] ever_rd;
    logic       prev_v, prev_r;
    logic [7:0] prev_d;
    logic [1:0] prev_c;
    int log_ch [$];
    int log_dat [$];
    int log_last [$];
    int log_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] head(input int c);
        return 8'(c * 16 + fptr[c]);
    endfunction

    task automatic drive_fifos();
        for (int c = 0; c < 4; c++) begin
            ch_dout[c*8 +: 8] = head(c);
            ch_empty[c]       = (fcnt[c] == 0);
        end
    endtask

    task automatic clear_log();
        log_ch.delete(); log_dat.delete(); log_last.delete(); log_cyc.delete();
        viol = 0; cyc = 0; ever_rd = 4'b0000; prev_v = 1'b0; prev_r = 1'b0;
    endtask

    // Per-cycle observation: pop must equal handshake, data must be the FIFO head, stalls hold.
    task automatic sample();
        logic       hs;
        logic [3:0] exp_rd;
        cyc++;
        hs     = mif.valid & mif.ready;
        exp_rd = hs ? (4'b0001 << mif.ch) : 4'b0000;
        if (ch_rd_en !== exp_rd) viol++;
        ever_rd |= ch_rd_en;
        if (prev_v && !prev_r && !rst) begin
            if (!(mif.valid === 1'b1 && mif.data === prev_d && mif.ch === prev_c)) viol++;
        end
        if (hs) begin
            if (mif.data !== head(int'(mif.ch))) viol++;
            log_ch.push_back(int'(mif.ch));
            log_dat.push_back(int'(mif.data));
            log_last.push_back(int'(mif.last));
            log_cyc.push_back(cyc);
        end
        prev_v = mif.valid; prev_r = mif.ready; prev_d = mif.data; prev_c = mif.ch;
    endtask

    task automatic tick();
        logic [3:0] rd;
        rd = ch_rd_en;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (rd[c] && !rst) begin
                fptr[c]++;
                fcnt[c]--;
            end
        end
        if (tog) mif.ready = ~mif.ready;
        else     mif.ready = 1'b1;
        drive_fifos();
        #1;
        sample();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset(input logic [3:0] en);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            fcnt[c] = 0;
            fptr[c] = 0;
        end
        cfg_en    = en;
        tog       = 1'b0;
        mif.ready = 1'b1;
        drive_fifos();
        clear_log();
        @(posedge clk);
        #2;
    endtask

    int err;
    int n, base, ch, k;

    initial begin
        rst = 1'b1; cfg_en = 4'b0000; mif.ready = 1'b1; ch_dout = '0; ch_empty = 4'b1111;

        // 1: single channel, three words
        apply_reset(4'b1111);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", mif.valid, 1'b0);
        chk("rst_rd_en", ch_rd_en, 4'b0000);
        chk("rst_last", mif.last, 1'b0);
        chk("rst_wc", word_count, 16'd0);
        fcnt[0] = 3; drive_fifos(); #1;
        rst = 1'b0;
        run(8);
        chk("t1_count", log_ch.size(), 3);
        err = 0;
        for (int i = 0; i < log_ch.size(); i++)
            if (log_ch[i] != 0 || log_dat[i] != i || log_last[i] != 0) err++;
        chk("t1_seq", err, 0);
        chk("t1_wc", word_count, 16'd3);
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_valid", mif.valid, 1'b0);
        chk("t1_first_cyc", log_cyc[0], 1);
        chk("t1_viol", viol, 0);

        // 2: all four channels, fair rotation with full bursts
        apply_reset(4'b1111);
        for (int c = 0; c < 4; c++) fcnt[c] = 10;
        drive_fifos(); #1;
        rst = 1'b0;
        run(70);
        chk("t2_count", log_ch.size(), 40);
        err = 0; k = 0;
        for (int g = 0; g < 12; g++) begin
            ch = g % 4; n = (g < 8) ? 4 : 2; base = (g / 4) * 4;
            for (int j = 0; j < n; j++) begin
                if (k < log_ch.size()) begin
                    if (log_ch[k] != ch || log_dat[k] != ch * 16 + base + j ||
                        log_last[k] != ((n == 4 && j == 3) ? 1 : 0)) err++;
                end
                k++;
            end
        end
        chk("t2_seq", err, 0);
        err = 0;
        for (int g = 0; g < 7; g++)
            if (log_cyc.size() >= 32 && log_cyc[4*g+4] - log_cyc[4*g+3] != 2) err++;
        chk("t2_gap", err, 0);
        chk("t2_wc", word_count, 16'd40);
        chk("t2_viol", viol, 0);

        // 3: ch2 alone with m_ready toggling
        apply_reset(4'b1111);
        fcnt[2] = 4; drive_fifos(); #1;
        tog = 1'b1;
        rst = 1'b0;
        run(16);
        chk("t3_count", log_ch.size(), 4);
        err = 0;
        for (int i = 0; i < log_ch.size(); i++)
            if (log_ch[i] != 2 || log_dat[i] != 32 + i) err++;
        chk("t3_seq", err, 0);
        chk("t3_last", (log_last.size() == 4) ? log_last[3] : -1, 1);
        chk("t3_wc", word_count, 16'd4);
        chk("t3_viol", viol, 0);

        // 4: short burst on ch1 ends early, rotation continues past it
        apply_reset(4'b1111);
        fcnt[1] = 2; fcnt[2] = 2; fcnt[3] = 2; drive_fifos(); #1;
        rst = 1'b0;
        run(18);
        chk("t4_count", log_ch.size(), 6);
        err = 0;
        for (int i = 0; i < log_ch.size(); i++)
            if (log_ch[i] != 1 + i / 2 || log_dat[i] != (1 + i / 2) * 16 + i % 2 || log_last[i] != 0) err++;
        chk("t4_seq", err, 0);
        chk("t4_viol", viol, 0);

        // 5: only channels 1 and 3 enabled
        apply_reset(4'b1010);
        for (int c = 0; c < 4; c++) fcnt[c] = 10;
        drive_fifos(); #1;
        rst = 1'b0;
        run(40);
        chk("t5_count", log_ch.size(), 20);
        err = 0; k = 0;
        for (int g = 0; g < 6; g++) begin
            ch = (g % 2 == 1) ? 3 : 1; n = (g < 4) ? 4 : 2; base = (g / 2) * 4;
            for (int j = 0; j < n; j++) begin
                if (k < log_ch.size())
                    if (log_ch[k] != ch || log_dat[k] != ch * 16 + base + j) err++;
                k++;
            end
        end
        chk("t5_seq", err, 0);
        chk("t5_no_rd_0_2", ever_rd & 4'b0101, 4'b0000);
        chk("t5_untouched", fcnt[0] + fcnt[2], 20);
        chk("t5_viol", viol, 0);

        // 6: reset asserted mid-burst with a handshake pending
        apply_reset(4'b1111);
        for (int c = 0; c < 4; c++) fcnt[c] = 10;
        drive_fifos(); #1;
        rst = 1'b0;
        for (int i = 0; i < 12 && log_ch.size() < 3; i++) tick();
        chk("t6_reach", log_ch.size(), 3);
        chk("t6_rd_pre", ch_rd_en, 4'b0001);
        rst = 1'b1;
        #1;
        chk("t6_rd_rst", ch_rd_en, 4'b0000);
        chk("t6_valid_rst", mif.valid, 1'b0);
        chk("t6_wc_rst", word_count, 16'd0);
        run(2);
        rst = 1'b0;
        clear_log();
        run(10);
        chk("t6_first_ch", (log_ch.size() > 0) ? log_ch[0] : -1, 0);
        chk("t6_first_dat", (log_dat.size() > 0) ? log_dat[0] : -1, 2);
        chk("t6_wc", word_count, 16'(log_ch.size()));
        chk("t6_viol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
